// File: rtl/pe_pkg.sv
// Shared widths, pin-map constants and readout selector for the systolic PE.
package pe_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 24;
   localparam int PROD_W = 16;

   // Readout byte selector carried on uio_in[4:3].
   typedef enum logic [1:0] {
      SEL_B0   = 2'd0,
      SEL_B1   = 2'd1,
      SEL_B2   = 2'd2,
      SEL_AFWD = 2'd3
   } out_sel_e;

   // Control bit positions on uio_in.
   localparam int UIO_LOAD_W = 0;
   localparam int UIO_VALID  = 1;
   localparam int UIO_CLEAR  = 2;
   localparam int UIO_SEL_LO = 3;
   localparam int UIO_SEL_HI = 4;

   // Status bit positions on uio_out.
   localparam int UIO_VALID_OUT = 5;
   localparam int UIO_OVF       = 6;
   localparam int UIO_WLOADED   = 7;

   // Only the three status bits are driven outward.
   localparam logic [7:0] UIO_OE_MASK = 8'b1110_0000;

   // Sign-extend a product to accumulator width.
   function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

endpackage

// File: rtl/pe_mac.sv
// Weight register, signed multiply-accumulate with sticky overflow, and
// activation/valid forwarding for chaining into a neighbouring PE.
module pe_mac
   import pe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ena,
   input  logic              i_load_w,
   input  logic              i_valid,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_a,
   output logic [ACC_W-1:0]  o_acc,
   output logic [DATA_W-1:0] o_a_fwd,
   output logic              o_valid_out,
   output logic              o_ovf,
   output logic              o_weight_loaded
);

   logic signed [DATA_W-1:0] r_weight;
   logic                     r_weight_loaded;
   logic [ACC_W-1:0]         r_acc;
   logic                     r_ovf;
   logic [DATA_W-1:0]        r_a_fwd;
   logic                     r_valid_out;

   logic signed [PROD_W-1:0] w_prod;
   logic [ACC_W-1:0]         w_prod_ext;
   logic [ACC_W-1:0]         w_acc_base;
   logic [ACC_W-1:0]         w_sum;
   logic [ACC_W-1:0]         w_acc_next;
   logic                     w_ovf_now;
   logic                     w_ovf_next;

   // The MAC always uses the weight held before this edge, so a same-cycle
   // load only affects the following MAC.
   assign w_prod     = PROD_W'($signed(i_a)) * PROD_W'(r_weight);
   assign w_prod_ext = sext_prod(w_prod);

   // Next accumulator value: clear zeroes the base, then the product is added.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
      w_acc_base = i_clear ? '0 : r_acc;
      w_sum      = w_acc_base + w_prod_ext;
      w_acc_next = w_acc_base;
      w_ovf_now  = 1'b0;
      if (i_valid) begin
         w_acc_next = w_sum;
         w_ovf_now  = (w_acc_base[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != w_acc_base[ACC_W-1]);
      end
      w_ovf_next = i_clear ? 1'b0 : (r_ovf | w_ovf_now);
   end

   // Accumulator and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (i_ena) begin
         // NOTE: non-blocking assignments make every register sample pre-edge values, matching flop behaviour.
         r_acc <= w_acc_next;
         r_ovf <= w_ovf_next;
      end
   end

   // Weight load plus activation/valid forwarding to the neighbouring PE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_weight        <= '0;
         r_weight_loaded <= 1'b0;
         r_a_fwd         <= '0;
         r_valid_out     <= 1'b0;
      end else if (i_ena) begin
         if (i_load_w) begin
            r_weight        <= $signed(i_a);
            r_weight_loaded <= 1'b1;
         end
         if (i_valid) begin
            r_a_fwd <= i_a;
         end
         r_valid_out <= i_valid;
      end
   end

   assign o_acc           = r_acc;
   assign o_a_fwd         = r_a_fwd;
   assign o_valid_out     = r_valid_out;
   assign o_ovf           = r_ovf;
   assign o_weight_loaded = r_weight_loaded;

endmodule

// File: rtl/tt_um_systolic_pe.sv
// TinyTapeout wrapper: maps pins onto the PE, muxes the byte readout and
// drives the fixed output-enable pattern.
module tt_um_systolic_pe
   import pe_pkg::*;
(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   logic [ACC_W-1:0]  w_acc;
   logic [DATA_W-1:0] w_a_fwd;
   logic              w_valid_out;
   logic              w_ovf;
   logic              w_weight_loaded;
   out_sel_e          w_sel;
   logic              w_unused;

   assign w_sel    = out_sel_e'(uio_in[UIO_SEL_HI:UIO_SEL_LO]);
   assign w_unused = &{1'b0, uio_in[7:5]};

   pe_mac u_pe_mac (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_ena           (ena),
      .i_load_w        (uio_in[UIO_LOAD_W]),
      .i_valid         (uio_in[UIO_VALID]),
      .i_clear         (uio_in[UIO_CLEAR]),
      .i_a             (ui_in),
      .o_acc           (w_acc),
      .o_a_fwd         (w_a_fwd),
      .o_valid_out     (w_valid_out),
      .o_ovf           (w_ovf),
      .o_weight_loaded (w_weight_loaded)
   );

   // Readout mux: only registered values reach uo_out; the selector just picks one.
   always_comb begin
      uo_out = '0;
      unique case (w_sel)
         SEL_B0:   uo_out = w_acc[7:0];
         SEL_B1:   uo_out = w_acc[15:8];
         SEL_B2:   uo_out = w_acc[23:16];
         SEL_AFWD: uo_out = w_a_fwd;
         default:  uo_out = '0;
      endcase
   end

   // Status byte: three flags on the top bits, the rest tied low.
   always_comb begin
      uio_out                = '0;
      uio_out[UIO_VALID_OUT] = w_valid_out;
      uio_out[UIO_OVF]       = w_ovf;
      uio_out[UIO_WLOADED]   = w_weight_loaded;
   end

   assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_systolic_pe.sv
// Self-checking bench for tt_um_systolic_pe: a behavioural reference model
// feeds a scoreboard queue, a vector table carries hand-derived accumulator
// values, and short hand sequences cover overflow and asynchronous reset.
module tb_tt_um_systolic_pe;

   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       ena;
   logic       clk;
   logic       rst_n;

   tt_um_systolic_pe dut (
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [23:0] acc;
      logic [7:0]  a_fwd;
      logic        vo;
      logic        ovf;
      logic        wl;
   } exp_t;

   typedef struct {
      logic        en;
      logic        ld;
      logic        vl;
      logic        cl;
      logic [7:0]  a;
      logic [23:0] exp_acc;
      logic        exp_ovf;
      string       name;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t sb[$];

   // Reference model state
   logic [23:0] m_acc;
   logic [7:0]  m_w;
   logic [7:0]  m_afwd;
   logic        m_vo;
   logic        m_ovf;
   logic        m_wl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_acc = '0; m_w = '0; m_afwd = '0; m_vo = 1'b0; m_ovf = 1'b0; m_wl = 1'b0;
   endfunction

   function automatic void model_step(input logic en, ld, vl, cl, input logic [7:0] a);
      int  prod, base, full;
      logic ovf_now;
      if (!en) return;
      prod    = int'($signed(a)) * int'($signed(m_w));
      base    = cl ? 0 : int'($signed(m_acc));
      full    = base + (vl ? prod : 0);
      ovf_now = vl && (full > 8388607 || full < -8388608);
      m_acc   = full[23:0];
      m_ovf   = cl ? 1'b0 : (m_ovf | ovf_now);
      if (ld) begin
         m_w  = a;
         m_wl = 1'b1;
      end
      if (vl) m_afwd = a;
      m_vo = vl;
   endfunction

   function automatic exp_t model_snapshot();
      exp_t e;
      e.acc = m_acc; e.a_fwd = m_afwd; e.vo = m_vo; e.ovf = m_ovf; e.wl = m_wl;
      return e;
   endfunction

   // Walk all four readout selects and the status/oe bytes.
   task automatic compare_state(input exp_t e, input string tag);
      logic [7:0] exp_b;
      for (int s = 0; s < 4; s++) begin
         uio_in[4:3] = 2'(s);
         #1;
         case (s)
            0:       exp_b = e.acc[7:0];
            1:       exp_b = e.acc[15:8];
            2:       exp_b = e.acc[23:16];
            default: exp_b = e.a_fwd;
         endcase
         check($sformatf("%s/sel%0d", tag, s), 32'(uo_out), 32'(exp_b));
      end
      check({tag, "/uio_out"}, 32'(uio_out), 32'({e.wl, e.ovf, e.vo, 5'b0}));
      check({tag, "/uio_oe"}, 32'(uio_oe), 32'h0000_00E0);
   endtask

   task automatic read_acc(output logic [23:0] acc);
      for (int s = 0; s < 3; s++) begin
         uio_in[4:3] = 2'(s);
         #1;
         acc[s*8 +: 8] = uo_out;
      end
   endtask

   // One clock of stimulus: drive at negedge, push the model's prediction,
   // pop and compare after the edge, then park with ena low.
   task automatic step(input logic en, ld, vl, cl, input logic [7:0] a, input string tag);
      exp_t e;
      @(negedge clk);
      ena    = en;
      ui_in  = a;
      uio_in = {3'($urandom_range(0, 7)), 2'b00, cl, vl, ld};
      model_step(en, ld, vl, cl, a);
      sb.push_back(model_snapshot());
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare_state(e, tag);
      ena    = 1'b0;
      uio_in = 8'h00;
   endtask

   vec_t        vecs[12];
   logic [23:0] acc_rd;

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 24'h000000, 1'b0, "load_w3"};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 24'h00000F, 1'b0, "mac_a5"};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 24'h00000F, 1'b0, "idle"};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 24'h00000C, 1'b0, "clr_val_ld"};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 24'h000010, 1'b0, "mac_new_w"};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 24'h000000, 1'b0, "clear"};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 24'h000000, 1'b0, "load_wm2"};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h07, 24'hFFFFF2, 1'b0, "mac_a7"};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 24'hFFFFEE, 1'b0, "mac_a2"};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 24'hFFFFEE, 1'b0, "ena_low"};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 24'hFFFF3A, 1'b0, "ena_high"};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 24'h000000, 1'b0, "clear2"};

      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      model_reset();
      #25;
      compare_state(model_snapshot(), "reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven basic, signed, simultaneous-event and enable cases.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].en, vecs[i].ld, vecs[i].vl, vecs[i].cl, vecs[i].a, vecs[i].name);
         read_acc(acc_rd);
         check({vecs[i].name, "/tbl_acc"}, 32'(acc_rd), 32'(vecs[i].exp_acc));
         check({vecs[i].name, "/tbl_ovf"}, 32'(uio_out[6]), 32'(vecs[i].exp_ovf));
      end

      // Overflow: (-128)*(-128) = +16384 per MAC; the 512th crosses 2^23.
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h80, "load_w80");
      for (int i = 0; i < 511; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 8'h80, $sformatf("ovf_run%0d", i));
      end
      read_acc(acc_rd);
      check("ovf_pre_acc", 32'(acc_rd), 32'h007F_C000);
      check("ovf_pre_flag", 32'(uio_out[6]), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h80, "ovf_cross");
      read_acc(acc_rd);
      check("ovf_wrap_acc", 32'(acc_rd), 32'h0080_0000);
      check("ovf_set", 32'(uio_out[6]), 32'd1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h80, "ovf_after");
      read_acc(acc_rd);
      check("ovf_after_acc", 32'(acc_rd), 32'h0080_4000);
      check("ovf_sticky", 32'(uio_out[6]), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "ovf_idle");
      check("ovf_sticky_idle", 32'(uio_out[6]), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "ovf_clear");
      read_acc(acc_rd);
      check("ovf_clr_acc", 32'(acc_rd), 32'h0);
      check("ovf_clr_flag", 32'(uio_out[6]), 32'd0);

      // Asynchronous reset asserted between edges while a MAC is pending.
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h03, "rst_load");
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h05, "rst_mac");
      @(negedge clk);
      ena    = 1'b1;
      ui_in  = 8'h05;
      uio_in = 8'b000_00_010;
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_state(model_snapshot(), "async_rst");
      @(posedge clk);
      #1;
      compare_state(model_snapshot(), "rst_held");
      ena    = 1'b0;
      uio_in = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h02, "post_rst_w0");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, "post_rst_load");
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h09, "post_rst_mac");
      read_acc(acc_rd);
      check("post_rst_acc", 32'(acc_rd), 32'h9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
